shift_add_multiplier: RTL and testbench

Sequential unsigned WIDTH x WIDTH multiplier using the radix-2 shift-and-add method. It drives one WIDTH-bit ripple_carry_adder instance with one partial product per cycle, registers the adder's sum/cout back into an accumulator, and shifts. Operands enter through a valid/ready input handshake. The 2*WIDTH-bit product leaves through a valid/ready output handshake. The block sits directly upstream of the adder and consumes its result every cycle.

---
 rtl/mul_pkg.sv | 15 +
 rtl/ripple_carry_adder.sv | 23 ++
 rtl/shift_add_multiplier.sv | 88 ++++++++
 tb/tb_shift_add_multiplier.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Counter must hold 0..WIDTH, so it needs enough bits for WIDTH itself.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one add-and-shift step per cycle
// through a single ripple-carry adder, with valid/ready on both sides.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = cnt_w(WIDTH);

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] p_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               last;

    // Upper half of P accumulates; the low bit of P selects the partial product.
    assign addend = p_q[0] ? a_q : '0;
    assign last   = (cnt_q == CW'(WIDTH - 1));

    ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
        .a    (p_q[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= multiplicand;
                        p_q   <= {{WIDTH{1'b0}}, multiplier};
                        cnt_q <= '0;
                    end
                end
                BUSY: begin
                    // Carry re-enters as the new MSB so nothing is lost in the shift.
                    p_q   <= {cout, sum, p_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY) || (state_q == DONE);
    assign product   = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed + random bench for shift_add_multiplier with a product scoreboard.
module tb_shift_add_multiplier;
    import mul_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           busy;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full transaction; hold = cycles out_ready stays low after out_valid rises.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit ign);
        int cyc;
        logic [2*W-1:0] exp;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        out_ready    = 1'($urandom_range(0, 1));
        exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        if (ign) begin
            multiplicand = 8'd7;
            multiplier   = 8'd7;
            in_valid     = 1'b1;
        end else begin
            in_valid     = 1'b0;
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
        end
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(W));
        in_valid  = 1'b0;
        out_ready = (hold == 0);
        exp = exp_q.pop_front();
        for (int k = 0; k < hold; k++) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check($sformatf("hold_product %0d*%0d", a, b), 32'(product), 32'(exp));
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("out_valid", 32'(out_valid), 32'd1);
        check($sformatf("product %0d*%0d", a, b), 32'(product), 32'(exp));
        @(negedge clk);
        check("in_ready_after_done", 32'(in_ready), 32'd1);
        check("out_valid_after_done", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    // Invariants sampled just before each rising edge.
    logic           hold_prev = 1'b0;
    logic [2*W-1:0] prod_prev = '0;
    always @(posedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(out_valid && in_ready)) else begin
                errors++;
                $error("FAIL valid_ready_overlap: observed 1 expected 0");
            end
            if (hold_prev) begin
                checks++;
                assert (product === prod_prev) else begin
                    errors++;
                    $error("FAIL product_stable: observed %0d expected %0d", product, prod_prev);
                end
            end
            if (dut.state_q == BUSY) begin
                checks++;
                assert (dut.cnt_q <= W - 1) else begin
                    errors++;
                    $error("FAIL count_range: observed %0d expected <= %0d", dut.cnt_q, W - 1);
                end
            end
        end
        hold_prev = rst_n && out_valid && !out_ready;
        prod_prev = product;
    end

    initial begin
        int cyc;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd13, 8'd11, 0, 1'b0);
        run_op(8'd255, 8'd255, 0, 1'b0);
        run_op(8'd0, 8'd200, 0, 1'b0);
        run_op(8'd200, 8'd0, 0, 1'b0);
        run_op(8'd1, 8'd255, 0, 1'b0);
        run_op(8'd100, 8'd3, 5, 1'b0);
        run_op(8'd9, 8'd9, 0, 1'b1);
        run_op(8'd7, 8'd7, 0, 1'b0);

        // Reset in the middle of a computation discards it.
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        multiplicand = 8'd50;
        multiplier   = 8'd3;
        in_valid     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("cnt_before_reset", 32'(dut.cnt_q), 32'd4);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        run_op(8'd6, 8'd7, 0, 1'b0);

        repeat (1000) run_op(8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
